// File: rtl/primus_pkg.sv
// Shared core definitions: fetch FSM states, IF/ID payload and architectural constants.
package primus_pkg;

    localparam int          XLEN                 = 32;
    localparam logic [31:0] NOP_INST             = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// presents a registered IF/ID payload to decode over a valid/ready handshake.
//
// state | meaning
// BOOT  | single post-reset cycle, no fetch
// RUN   | fetching, one instruction per cycle when downstream drains
// HALT  | no new fetches; pending output may still be accepted
// ERR   | misaligned redirect seen; idle until aligned redirect or reset
module instruction_fetch
    import primus_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          IMEM_WORDS   = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        fetch_err_o,
    output logic        oor_o
);

    localparam logic [31:0] IMEM_WORDS_L = 32'(IMEM_WORDS);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    if_id_t       if_id_q;
    logic         valid_q;
    logic         fetch_err_q;
    logic         drain_ok;

    // Output slot is free for a new fetch when empty or being consumed this cycle.
    assign drain_ok = !valid_q || ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            if_id_q.pc   <= 32'h0000_0000;
            if_id_q.inst <= NOP_INST;
            valid_q      <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else if (state_q == BOOT) begin
            state_q <= halt_i ? HALT : RUN;
        end else if (redirect_i) begin
            valid_q <= 1'b0;
            pc_q    <= {redirect_pc_i[31:2], 2'b00};
            if (redirect_pc_i[1:0] != 2'b00) begin
                state_q     <= ERR;
                fetch_err_q <= 1'b1;
            end else begin
                state_q     <= halt_i ? HALT : RUN;
                fetch_err_q <= 1'b0;
            end
        end else begin
            case (state_q)
                RUN, HALT: begin
                    if (halt_i) begin
                        state_q <= HALT;
                        if (valid_q && ready_i) begin
                            valid_q <= 1'b0;
                        end
                    end else begin
                        // Leaving HALT resumes fetching in the same cycle.
                        state_q <= RUN;
                        if (drain_ok) begin
                            if_id_q.inst <= imem_inst_i;
                            if_id_q.pc   <= pc_q;
                            valid_q      <= 1'b1;
                            pc_q         <= pc_q + 32'd4;
                        end
                    end
                end
                ERR: begin
                    valid_q     <= 1'b0;
                    fetch_err_q <= 1'b1;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

    assign imem_addr_o = pc_q;
    assign inst_o      = if_id_q.inst;
    assign pc_o        = if_id_q.pc;
    assign valid_o     = valid_q;
    assign fetch_err_o = fetch_err_q;
    assign oor_o       = ({2'b00, pc_q[31:2]} >= IMEM_WORDS_L);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, stall, redirect, error, halt,
// PC wraparound with out-of-range flag, and asynchronous reset.
module tb_instruction_fetch;
    import primus_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] imem_addr_o, imem_inst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic [31:0] inst_o, pc_o;
    logic        valid_o, ready_i, fetch_err_o, oor_o;

    logic [31:0] w_addr, w_inst, w_inst_o, w_pc_o;
    logic        w_valid, w_err, w_oor;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    // Memory word k holds 0x1000 + k.
    assign imem_inst_i = 32'h0000_1000 + {2'b00, imem_addr_o[31:2]};
    assign w_inst      = 32'h0000_1000 + {2'b00, w_addr[31:2]};

    instruction_fetch u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_addr_o  (imem_addr_o),
        .imem_inst_i  (imem_inst_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .halt_i       (halt_i),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .fetch_err_o  (fetch_err_o),
        .oor_o        (oor_o)
    );

    instruction_fetch #(.RESET_VECTOR(32'hFFFF_FFF8), .IMEM_WORDS(1024)) u_dut_wrap (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .imem_addr_o  (w_addr),
        .imem_inst_i  (w_inst),
        .redirect_i   (1'b0),
        .redirect_pc_i(32'h0000_0000),
        .halt_i       (1'b0),
        .inst_o       (w_inst_o),
        .pc_o         (w_pc_o),
        .valid_o      (w_valid),
        .ready_i      (1'b1),
        .fetch_err_o  (w_err),
        .oor_o        (w_oor)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni        = 1'b0;
        ready_i       = 1'b1;
        halt_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        tick();
        tick();
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_pc", pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_err", {31'b0, fetch_err_o}, 32'd0);
        check("rst_w_addr", w_addr, 32'hFFFF_FFF8);
        rst_ni = 1'b1;

        // BOOT cycle: nothing presented yet.
        tick();
        check("boot_valid", {31'b0, valid_o}, 32'd0);
        check("boot_oor", {31'b0, oor_o}, 32'd0);
        check("w_oor_fff8", {31'b0, w_oor}, 32'd1);

        tick();
        check("s0_valid", {31'b0, valid_o}, 32'd1);
        check("s0_pc", pc_o, 32'h0);
        check("s0_inst", inst_o, 32'h1000);
        check("w_pc0", w_pc_o, 32'hFFFF_FFF8);
        check("w_oor_fffc", {31'b0, w_oor}, 32'd1);
        tick();
        check("s1_pc", pc_o, 32'h4);
        check("s1_inst", inst_o, 32'h1001);
        check("w_pc1", w_pc_o, 32'hFFFF_FFFC);
        check("w_oor_0", {31'b0, w_oor}, 32'd0);
        tick();
        check("s2_pc", pc_o, 32'h8);
        check("s2_inst", inst_o, 32'h1002);
        check("w_pc2", w_pc_o, 32'h0);
        check("w_inst2", w_inst_o, 32'h1000);

        // Stall at pc 0x8 for three cycles.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'b0, valid_o}, 32'd1);
            check("stall_pc", pc_o, 32'h8);
            check("stall_inst", inst_o, 32'h1002);
            check("stall_addr", imem_addr_o, 32'hC);
        end
        ready_i = 1'b1;
        tick();
        check("unstall_pc", pc_o, 32'hC);
        check("unstall_inst", inst_o, 32'h1003);
        tick();
        check("pc10", pc_o, 32'h10);

        // Redirect while stalled at 0x10.
        ready_i       = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        ready_i    = 1'b1;
        check("redir_flush", {31'b0, valid_o}, 32'd0);
        check("redir_addr", imem_addr_o, 32'h40);
        tick();
        check("redir_valid", {31'b0, valid_o}, 32'd1);
        check("redir_pc", pc_o, 32'h40);
        check("redir_inst", inst_o, 32'h1010);

        // Misaligned redirect -> ERR.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h42;
        tick();
        redirect_i = 1'b0;
        check("err_flag", {31'b0, fetch_err_o}, 32'd1);
        check("err_valid", {31'b0, valid_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("err_hold_valid", {31'b0, valid_o}, 32'd0);
            check("err_hold_flag", {31'b0, fetch_err_o}, 32'd1);
            check("err_hold_addr", imem_addr_o, 32'h40);
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        tick();
        redirect_i = 1'b0;
        check("err_clear", {31'b0, fetch_err_o}, 32'd0);
        check("err_clear_valid", {31'b0, valid_o}, 32'd0);
        tick();
        check("rec_pc", pc_o, 32'h80);
        check("rec_inst", inst_o, 32'h1020);
        tick();
        check("rec_pc2", pc_o, 32'h84);

        // Halt for four cycles: 0x84 drains, pc_q frozen at 0x88.
        halt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_valid", {31'b0, valid_o}, 32'd0);
            check("halt_addr", imem_addr_o, 32'h88);
        end
        halt_i = 1'b0;
        tick();
        check("resume_valid", {31'b0, valid_o}, 32'd1);
        check("resume_pc", pc_o, 32'h88);
        check("resume_inst", inst_o, 32'h1022);
        tick();
        check("resume_pc2", pc_o, 32'h8C);

        // Asynchronous reset mid-run, observed before the next clock edge.
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid", {31'b0, valid_o}, 32'd0);
        check("arst_inst", inst_o, 32'h0000_0013);
        check("arst_pc", pc_o, 32'h0);
        check("arst_addr", imem_addr_o, 32'h0);
        check("arst_w_addr", w_addr, 32'hFFFF_FFF8);
        tick();
        rst_ni = 1'b1;
        tick();
        check("arst_boot", {31'b0, valid_o}, 32'd0);
        tick();
        check("arst_pc0", pc_o, 32'h0);
        check("arst_v0", {31'b0, valid_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_memory. Owns the program counter and drives the memory word address. Captures the combinationally-read instruction into a registered IF/ID output with a valid/ready handshake toward decode. Handles redirects from execute (branch/jump), halt requests, and misaligned-target errors.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
IMEM_WORDS, 1024, instruction memory depth in words; used only for the out-of-range flag.

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
imem_addr_o  output  32  byte address to instruction_memory; equals pc_q combinationally
imem_inst_i  input  32  instruction word returned combinationally for imem_addr_o
redirect_i  input  1  one-cycle pulse: load new PC, flush output
redirect_pc_i  input  32  redirect target byte address
halt_i  input  1  level: stop issuing new fetches while high
inst_o  output  32  fetched instruction to decode
pc_o  output  32  byte address of inst_o
valid_o  output  1  inst_o/pc_o valid
ready_i  input  1  decode accepts when valid_o && ready_i
fetch_err_o  output  1  sticky: misaligned redirect target
oor_o  output  1  pc_q word index >= IMEM_WORDS (combinational)

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_VECTOR, inst_o=32'h0000_0013 (NOP), pc_o=0, valid_o=0, fetch_err_o=0, state=BOOT.
- FSM states BOOT, RUN, HALT, ERR.
  - BOOT: exactly one cycle, no fetch, valid_o stays 0; then RUN, or HALT if halt_i=1.
  - RUN: fetch fires when !redirect_i && (!valid_o || ready_i). Then inst_o<=imem_inst_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4. Goes to HALT when halt_i=1; the fetch still fires that cycle only if halt_i=0.
  - HALT: no fires. If valid_o && ready_i then valid_o<=0. Returns to RUN on the first cycle with halt_i=0; fetching resumes in that cycle.
  - ERR: no fires, valid_o<=0, fetch_err_o=1. Left only by an aligned redirect (goes to RUN) or by reset.
- Stall: valid_o && !ready_i holds inst_o, pc_o, valid_o and pc_q stable. No fetch, no pc increment.
- Drain: !valid_o, or valid_o && ready_i, allows a fire in the same cycle. Throughput is 1 instr/cycle with no bubbles.
- Redirect has top priority in every state except BOOT, where it is ignored. When redirect_i=1:
  - valid_o<=0 (flush, even when stalled); no fire that cycle.
  - pc_q<={redirect_pc_i[31:2],2'b00}.
  - If redirect_pc_i[1:0]!=0: state<=ERR, fetch_err_o<=1. Otherwise state<=RUN, or HALT if halt_i=1, and fetch_err_o<=0.
  - The first fetch from the new PC fires the cycle after the redirect.
- PC arithmetic: 32-bit, wraps modulo 2^32; 0xFFFF_FFFC+4 = 0x0000_0000.
- imem_addr_o = pc_q always, including while stalled or halted. Memory reads have no side effects.
- oor_o = (pc_q[31:2] >= IMEM_WORDS). Informational only; fetch is not blocked.
- Reset mid-operation: all state returns to reset values immediately. Any pending output is discarded.
- ready_i is ignored when valid_o=0.

Decomposition:
- Shared package primus_pkg holds:
  - fetch_state_e enum (BOOT, RUN, HALT, ERR)
  - NOP_INST = 32'h0000_0013
  - XLEN = 32
  - default RESET_VECTOR
- if_id_t packed struct {pc, inst} for the IF/ID payload, reused by decode.
- No sub-module. The block is a single FSM plus PC and IF/ID registers, about 150 lines.

Test Plan:
- Reset then ready_i=1 constant, memory word k = 0x1000+k -> valid_o rises in cycle 2; pc_o = 0,4,8,... with inst_o = 0x1000,0x1001,... every cycle, no bubbles.
- Hold ready_i=0 for 3 cycles while valid_o=1 at pc_o=0x8 -> pc_o, inst_o and imem_addr_o (0xC) stay constant; after ready_i=1, next pc_o=0xC.
- Redirect to 0x40 while stalled at pc_o=0x10 -> valid_o=0 next cycle, then pc_o=0x40 with inst word 16; pc 0x14 is never presented.
- Redirect to 0x42 -> fetch_err_o=1, valid_o=0, no fetches for 5 cycles; then redirect to 0x80 -> fetch_err_o=0, pc_o=0x80 delivered.
- halt_i=1 for 4 cycles with ready_i=1 -> the in-flight instruction drains, valid_o=0, pc_q frozen; on halt_i=0, fetch resumes at the next sequential PC.
- RESET_VECTOR=0xFFFF_FFF8 -> pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. oor_o=1 at the first two PCs and 0 at 0x0 (IMEM_WORDS=1024). Assert rst_ni mid-run -> outputs return to reset values asynchronously.
